// File: rtl/fsm_mon_pkg.sv
// rtl/fsm_mon_pkg.sv - shared constants for the FSM output monitor
package fsm_mon_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   // x^19 + x^5 + x^2 + x + 1
   localparam logic [18:0] MISR_POLY = 19'h00027;

endpackage

// File: rtl/ev_fifo.sv
// rtl/ev_fifo.sv - change-event FIFO, wrap-bit pointers, head shown combinationally
module ev_fifo #(
   parameter int WIDTH = 35,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s_tvalid,
   input  logic [WIDTH-1:0] s_tdata,
   output logic             s_tready,
   output logic             m_tvalid,
   output logic [WIDTH-1:0] m_tdata,
   input  logic             m_tready
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic             empty, full, do_push, do_pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign m_tvalid = !empty;
   assign do_pop   = m_tvalid && m_tready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign s_tready = !full || do_pop;
   assign do_push  = s_tvalid && s_tready;
   assign m_tdata  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (do_push) begin
         mem_d[wr_ptr_q[AW-1:0]] = s_tdata;
         wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/fsm_out_monitor.sv
// rtl/fsm_out_monitor.sv - windowed MISR signature and change-event logger for an FSM output
module fsm_out_monitor
   import fsm_mon_pkg::*;
#(
   parameter int OUT_LEN  = 19,
   parameter int CNT_W    = 16,
   parameter int EV_DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     smp_valid,
   input  logic [OUT_LEN-1:0]       fsm_out,
   input  logic                     ev_ready,
   output logic                     ev_valid,
   output logic [CNT_W+OUT_LEN-1:0] ev_data,
   output logic [OUT_LEN-1:0]       signature,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic                     busy,
   output logic                     done,
   output logic                     overflow
);

   localparam logic [OUT_LEN-1:0] POLY     = OUT_LEN'(MISR_POLY);
   localparam logic [CNT_W-1:0]   CNT_LAST = {{(CNT_W-1){1'b1}}, 1'b0};

   logic [1:0]         state_q, state_d;
   logic [OUT_LEN-1:0] sig_q, sig_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ovf_q, ovf_d;
   logic               first_q, first_d;
   logic [OUT_LEN-1:0] last_q, last_d;
   logic               accept, push_req, push_ready;

   assign accept   = (state_q == ST_CAPTURE) && smp_valid;
   assign push_req = accept && (first_q || (fsm_out != last_q));

   always_comb begin
      state_d = state_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      first_d = first_q;
      last_d  = last_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_CAPTURE;
               sig_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               first_d = 1'b1;
            end
         end
         ST_CAPTURE: begin
            if (accept) begin
               sig_d   = {sig_q[OUT_LEN-2:0], 1'b0} ^ (sig_q[OUT_LEN-1] ? POLY : '0) ^ fsm_out;
               cnt_d   = cnt_q + 1'b1;
               first_d = 1'b0;
               last_d  = fsm_out;
            end
            if (push_req && !push_ready) begin
               ovf_d = 1'b1;
            end
            // The sample that fills the counter closes the window, so it never wraps.
            if (stop || (accept && (cnt_q == CNT_LAST))) begin
               state_d = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (!ev_valid) begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         sig_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         first_q <= 1'b0;
         last_q  <= '0;
      end else begin
         state_q <= state_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         first_q <= first_d;
         last_q  <= last_d;
      end
   end

   ev_fifo #(
      .WIDTH (CNT_W + OUT_LEN),
      .DEPTH (EV_DEPTH)
   ) u_ev_fifo (
      .clk      (clk),
      .rst_n    (rst),
      .s_tvalid (push_req),
      .s_tdata  ({cnt_q, fsm_out}),
      .s_tready (push_ready),
      .m_tvalid (ev_valid),
      .m_tdata  (ev_data),
      .m_tready (ev_ready)
   );

   assign signature = sig_q;
   assign cycle_cnt = cnt_q;
   assign overflow  = ovf_q;
   assign busy      = (state_q == ST_CAPTURE) || (state_q == ST_FLUSH);
   assign done      = (state_q == ST_DONE);

endmodule

// File: doc/fsm_out_monitor.md
FSM_OUT_MONITOR -- requirements
Module: fsm_out_monitor

Interface
REQ-001 SHALL have parameter OUT_LEN, default 19, giving the FSM output width under observation.
REQ-002 SHALL have parameter CNT_W, default 16, giving the cycle counter width.
REQ-003 SHALL have parameter EV_DEPTH, default 8, giving the change-event FIFO depth, a power of 2 and at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: a one-cycle pulse that opens a capture window.
REQ-007 SHALL have port stop, input, 1 bit: a one-cycle pulse that closes the capture window.
REQ-008 SHALL have port smp_valid, input, 1 bit: fsm_out is meaningful this cycle (driver low during the FSM's own reset vectors).
REQ-009 SHALL have port fsm_out, input, OUT_LEN bits: the output of the upstream FSM under test.
REQ-010 SHALL have port ev_ready, input, 1 bit: the consumer accepts the event at the FIFO head.
REQ-011 SHALL have port ev_valid, output, 1 bit: the FIFO is non-empty.
REQ-012 SHALL have port ev_data, output, CNT_W+OUT_LEN bits: {cycle index, sample} at the FIFO head.
REQ-013 SHALL have port signature, output, OUT_LEN bits: the MISR value.
REQ-014 SHALL have port cycle_cnt, output, CNT_W bits: the count of accepted samples in the window.
REQ-015 SHALL have port busy, output, 1 bit: high in CAPTURE and FLUSH.
REQ-016 SHALL have port done, output, 1 bit: high in DONE.
REQ-017 SHALL have port overflow, output, 1 bit: a sticky event-dropped flag.

Function
REQ-018 SHALL implement states IDLE, CAPTURE, FLUSH, DONE.
REQ-019 SHALL transition IDLE->CAPTURE on start, and DONE->CAPTURE on start.
REQ-020 SHALL transition CAPTURE->FLUSH on stop, or on the cycle where cycle_cnt reaches all-ones.
REQ-021 SHALL transition FLUSH->DONE when the FIFO is empty.
REQ-022 SHALL ignore start outside IDLE and DONE, and SHALL ignore stop outside CAPTURE.
REQ-023 SHALL, on entering CAPTURE, in the same edge, clear signature, cycle_cnt and overflow, and SHALL NOT clear the FIFO.
REQ-024 SHALL accept a sample only in CAPTURE with smp_valid=1; a sample present in the same cycle as the stop pulse is still accepted.
REQ-025 SHALL, per accepted sample: signature <= {signature[OUT_LEN-2:0],1'b0} XOR (signature[OUT_LEN-1] ? MISR_POLY : 0) XOR fsm_out; cycle_cnt <= cycle_cnt+1 (no wrap: saturating at all-ones ends the window per REQ-020).
REQ-026 SHALL push {cycle_cnt before increment, fsm_out} into the FIFO when the sample is either the first accepted in the window or differs from the previously accepted sample.
REQ-027 SHALL accept a push when the FIFO is full if a pop (ev_valid and ev_ready) occurs in the same cycle.
REQ-028 SHALL, when the FIFO is full with no pop, drop the push and set overflow until the next window start.
REQ-029 SHALL pop on ev_valid and ev_ready; ev_data SHALL be stable while ev_valid=1 and ev_ready=0.
REQ-030 SHALL drive ev_data combinationally from the FIFO head, with zero-latency visibility of a push on the following cycle.
REQ-031 SHALL update signature and cycle_cnt one cycle after the sample edge.

Reset
REQ-032 SHALL, on rst low, immediately go to IDLE and set signature=0, cycle_cnt=0, FIFO empty (ev_valid=0), ev_data=0, busy=0, done=0, overflow=0.
REQ-033 SHALL discard all captured state on a mid-window reset, and SHALL require a fresh start after rst deassertion.

Structure
REQ-034 SHALL place MISR_POLY (default 19'h00027, x^19+x^5+x^2+x+1) and the state enumeration in shared package fsm_mon_pkg.
REQ-035 SHALL implement the event FIFO as sub-module ev_fifo (parameterised width and depth, with a full/empty pointer plus wrap bit).

Verification
REQ-036 SHALL verify: start, then samples 0x00001, 0x00001, 0x00002 -> events {0,0x00001}, {2,0x00002}; cycle_cnt=3; signature=0x00004.
REQ-037 SHALL verify: smp_valid=0 for 3 cycles inside a window -> cycle_cnt unchanged and no events.
REQ-038 SHALL verify: 10 alternating samples with ev_ready=0 and EV_DEPTH=8 -> 8 events held, overflow=1, first event index 0.
REQ-039 SHALL verify: FIFO full with simultaneous push and pop -> push accepted, occupancy stays 8, overflow=0.
REQ-040 SHALL verify: stop with 3 events pending, ev_ready=1 -> FLUSH 3 cycles, then done=1 and busy=0.
REQ-041 SHALL verify: rst low mid-CAPTURE -> all outputs zero immediately; a subsequent start logs a first event at index 0.
